// File: rtl/alu_sequencer.sv
// Sequencer in front of the combinational decoder: latches switch operands,
// runs one op or a sweep of all 16 ops, and captures results for display.
module alu_sequencer #(
   parameter int unsigned DWELL = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        auto,
   input  logic [3:0]  sw_a,
   input  logic [3:0]  sw_b,
   input  logic [3:0]  sw_op,
   input  logic        sw_counter_mode,
   output logic [3:0]  dec_a,
   output logic [3:0]  dec_b,
   output logic [3:0]  dec_op,
   output logic        dec_counter_mode,
   input  logic [11:0] dec_bcd,
   input  logic        dec_c_out,
   input  logic [3:0]  dec_four_bit,
   output logic [11:0] res_bcd,
   output logic        res_c_out,
   output logic [3:0]  res_four_bit,
   output logic [3:0]  res_op,
   output logic        res_valid,
   output logic        busy,
   output logic        done
);

   localparam int unsigned CNT_W = 32;
   localparam int unsigned OP_W  = 4;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SETTLE  = 3'd1;
   localparam logic [2:0] S_CAPTURE = 3'd2;
   localparam logic [2:0] S_HOLD    = 3'd3;
   localparam logic [2:0] S_FINISH  = 3'd4;

   localparam logic [OP_W-1:0]  LAST_OP   = OP_W'(15);
   localparam logic [CNT_W-1:0] DWELL_LD  = CNT_W'(DWELL - 1);

   logic [2:0]       state, state_nxt;
   logic             mode, mode_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   logic [3:0]  dec_a_nxt, dec_b_nxt, dec_op_nxt;
   logic        dec_counter_mode_nxt;
   logic [11:0] res_bcd_nxt;
   logic        res_c_out_nxt;
   logic [3:0]  res_four_bit_nxt;
   logic [3:0]  res_op_nxt;
   logic        res_valid_nxt;
   logic        busy_nxt;
   logic        done_nxt;

   // State and all registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= S_IDLE;
         mode             <= 1'b0;
         cnt              <= '0;
         dec_a            <= '0;
         dec_b            <= '0;
         dec_op           <= '0;
         dec_counter_mode <= 1'b0;
         res_bcd          <= '0;
         res_c_out        <= 1'b0;
         res_four_bit     <= '0;
         res_op           <= '0;
         res_valid        <= 1'b0;
         busy             <= 1'b0;
         done             <= 1'b0;
      end else begin
         state            <= state_nxt;
         mode             <= mode_nxt;
         cnt              <= cnt_nxt;
         dec_a            <= dec_a_nxt;
         dec_b            <= dec_b_nxt;
         dec_op           <= dec_op_nxt;
         dec_counter_mode <= dec_counter_mode_nxt;
         res_bcd          <= res_bcd_nxt;
         res_c_out        <= res_c_out_nxt;
         res_four_bit     <= res_four_bit_nxt;
         res_op           <= res_op_nxt;
         res_valid        <= res_valid_nxt;
         busy             <= busy_nxt;
         done             <= done_nxt;
      end
   end

   // Next-state and next-register values
   always_comb begin
      state_nxt            = state;
      mode_nxt             = mode;
      cnt_nxt              = cnt;
      dec_a_nxt            = dec_a;
      dec_b_nxt            = dec_b;
      dec_op_nxt           = dec_op;
      dec_counter_mode_nxt = dec_counter_mode;
      res_bcd_nxt          = res_bcd;
      res_c_out_nxt        = res_c_out;
      res_four_bit_nxt     = res_four_bit;
      res_op_nxt           = res_op;
      res_valid_nxt        = res_valid;

      case (state)
         S_IDLE: begin
            if (start) begin
               dec_a_nxt            = sw_a;
               dec_b_nxt            = sw_b;
               dec_counter_mode_nxt = sw_counter_mode;
               mode_nxt             = auto;
               dec_op_nxt           = auto ? '0 : sw_op;
               res_valid_nxt        = 1'b0;
               state_nxt            = S_SETTLE;
            end
         end
         S_SETTLE: state_nxt = S_CAPTURE;
         S_CAPTURE: begin
            res_bcd_nxt      = dec_bcd;
            res_c_out_nxt    = dec_c_out;
            res_four_bit_nxt = dec_four_bit;
            res_op_nxt       = dec_op;
            res_valid_nxt    = 1'b1;
            // The sweep ends on op 15, so dec_op never wraps
            if (!mode || (dec_op == LAST_OP)) begin
               state_nxt = S_FINISH;
            end else begin
               cnt_nxt   = DWELL_LD;
               state_nxt = S_HOLD;
            end
         end
         S_HOLD: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - CNT_W'(1);
            end else begin
               dec_op_nxt = dec_op + OP_W'(1);
               state_nxt  = S_SETTLE;
            end
         end
         S_FINISH: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase

      // Status flags track the state being entered so they align with it
      busy_nxt = (state_nxt != S_IDLE);
      done_nxt = (state_nxt == S_FINISH);
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural decoder and
// cycle-count model of single and sweep runs.
module tb_alu_sequencer;

   localparam int unsigned DWELL = 4;
   localparam int PER = 2 + DWELL;
   localparam int SWEEP_DONE = 15 * PER + 3;

   logic        clk = 1'b0;
   logic        reset, start, auto, sw_counter_mode;
   logic [3:0]  sw_a, sw_b, sw_op;
   logic [3:0]  dec_a, dec_b, dec_op;
   logic        dec_counter_mode;
   logic [11:0] dec_bcd;
   logic        dec_c_out;
   logic [3:0]  dec_four_bit;
   logic [11:0] res_bcd;
   logic        res_c_out;
   logic [3:0]  res_four_bit, res_op;
   logic        res_valid, busy, done;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_sequencer #(.DWELL(DWELL)) dut (
      .clk(clk), .reset(reset), .start(start), .auto(auto),
      .sw_a(sw_a), .sw_b(sw_b), .sw_op(sw_op), .sw_counter_mode(sw_counter_mode),
      .dec_a(dec_a), .dec_b(dec_b), .dec_op(dec_op), .dec_counter_mode(dec_counter_mode),
      .dec_bcd(dec_bcd), .dec_c_out(dec_c_out), .dec_four_bit(dec_four_bit),
      .res_bcd(res_bcd), .res_c_out(res_c_out), .res_four_bit(res_four_bit),
      .res_op(res_op), .res_valid(res_valid), .busy(busy), .done(done)
   );

   // Stand-in decoder: {bcd[16:5], c_out[4], four_bit[3:0]}
   function automatic logic [16:0] dec_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [3:0] op, input logic cm);
      logic [4:0] s;
      s = 5'(a) + 5'(b) + 5'(op);
      return {op, a ^ b, s[3:0], s[4] ^ cm, (a & b) | op};
   endfunction

   logic [16:0] dm;
   always_comb begin
      dm           = dec_model(dec_a, dec_b, dec_op, dec_counter_mode);
      dec_bcd      = dm[16:5];
      dec_c_out    = dm[4];
      dec_four_bit = dm[3:0];
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_dec"}, 32'({dec_a, dec_b, dec_op, dec_counter_mode}), 32'd0);
      check({tag, "_res"}, 32'({res_bcd, res_c_out, res_four_bit, res_op}), 32'd0);
      check({tag, "_flags"}, 32'({res_valid, busy, done}), 32'd0);
   endtask

   task automatic run_single(input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] op, input logic cm);
      sw_a = a; sw_b = b; sw_op = op; sw_counter_mode = cm; auto = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      sw_a = 4'($urandom); sw_b = 4'($urandom); sw_op = 4'($urandom);
      check("s_c1_dec", 32'({dec_a, dec_b, dec_op, dec_counter_mode}), 32'({a, b, op, cm}));
      check("s_c1_flags", 32'({res_valid, busy, done}), 32'b010);
      step();
      check("s_c2_flags", 32'({busy, done}), 32'b10);
      step();
      check("s_c3_flags", 32'({res_valid, busy, done}), 32'b111);
      check("s_c3_res_op", 32'(res_op), 32'(op));
      check("s_c3_res", 32'({res_bcd, res_c_out, res_four_bit}), 32'(dec_model(a, b, op, cm)));
      step();
      check("s_c4_flags", 32'({res_valid, busy, done}), 32'b100);
   endtask

   // Sweep run; disturbs start/sw_a in cycle 20, optional reset at reset_cycle
   task automatic run_sweep(input logic [3:0] a, input logic [3:0] b, input logic cm,
                            input int reset_cycle);
      int n;
      sw_a = a; sw_b = b; sw_op = 4'($urandom); sw_counter_mode = cm; auto = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= SWEEP_DONE; c++) begin
         n = (c - 1) / PER;
         check("w_dec_op", 32'(dec_op), 32'(n > 15 ? 15 : n));
         check("w_frozen", 32'({dec_a, dec_b, dec_counter_mode}), 32'({a, b, cm}));
         check("w_flags", 32'({busy, done}), {30'd0, 1'b1, c == SWEEP_DONE});
         if (c >= 3 && (c - 3) % PER == 0) begin
            check("w_res_op", 32'(res_op), 32'((c - 3) / PER));
            check("w_res", 32'({res_bcd, res_c_out, res_four_bit}),
                  32'(dec_model(a, b, 4'((c - 3) / PER), cm)));
            check("w_valid", 32'(res_valid), 32'd1);
         end
         if (c == reset_cycle) begin
            reset = 1'b1;
            step();
            reset = 1'b0;
            check_zero("w_reset");
            for (int k = 0; k < 100; k++) begin
               step();
               check("w_post_reset", 32'({busy, done}), 32'd0);
            end
            return;
         end
         start = (c == 20);
         if (c == 20) sw_a = 4'd1;
         if (c < SWEEP_DONE) step();
      end
      step();
      check("w_end", 32'({res_valid, busy, done, res_op}), 32'({3'b100, 4'd15}));
   endtask

   initial begin
      reset = 1'b1; start = 1'b1; auto = 1'($urandom);
      sw_a = 4'($urandom); sw_b = 4'($urandom); sw_op = 4'($urandom);
      sw_counter_mode = 1'($urandom);
      step();
      check_zero("rst1");
      step();
      check_zero("rst2");
      reset = 1'b0; start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         sw_a = 4'($urandom); sw_op = 4'($urandom);
         step();
         check_zero("idle");
      end

      run_single(4'd3, 4'd5, 4'd2, 1'b0);
      run_sweep(4'd9, 4'd7, 1'b1, 0);
      run_sweep(4'd9, 4'd7, 1'b0, 40);
      run_single(4'($urandom), 4'($urandom), 4'd4, 1'($urandom));

      // Held start: back-to-back single runs with one IDLE between
      sw_a = 4'd6; sw_b = 4'd2; sw_op = 4'd11; sw_counter_mode = 1'b0; auto = 1'b0; start = 1'b1;
      step();
      for (int c = 1; c <= 11; c++) begin
         check("h_flags", 32'({busy, done}), {30'd0, c % 4 != 0, c % 4 == 3});
         check("h_dec_op", 32'(dec_op), 32'd11);
         if (c == 11) start = 1'b0;
         if (c < 11) step();
      end
      step();
      check("h_idle", 32'({busy, done}), 32'd0);
      step();
      check("h_idle2", 32'({busy, done}), 32'd0);

      for (int i = 0; i < 8; i++)
         run_single(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
      run_sweep(4'($urandom), 4'($urandom), 1'($urandom), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Controller that sits in front of the combinational `decoder` datapath (operands `a`/`b`, `op_code`, `counter_mode` → `BCD`, `c_out`, `four_bit_out`). It latches switch operands on a start request and drives them into the decoder. It then runs either one selected op code or an automatic sweep through all 16 op codes with a programmable dwell per op. After each op it captures the decoder's result into stable output registers for the seven-segment/VGA display path, and pulses `done` at the end of each run.

## Interface
- `DWELL`, default 4: cycles each op is held after capture in sweep mode; legal range 1..2^32-1. Board builds override it, e.g. 100_000_000.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; returns the block to IDLE with all registers zero.
- `start`  in  1  run request, level-sampled only in IDLE; ignored in every other state.
- `auto`  in  1  sampled with `start`: 0 = single op, 1 = sweep op codes 0..15.
- `sw_a`, `sw_b`, `sw_op`  in  4 each  operand and op code sources, sampled with `start`.
- `sw_counter_mode`  in  1  counter-mode source, sampled with `start`.
- `dec_a`, `dec_b`, `dec_op`  out  4 each  registered drive to the decoder's `a`, `b`, `op_code`.
- `dec_counter_mode`  out  1  registered drive to the decoder's `counter_mode`.
- `dec_bcd`  in  12  decoder `BCD` result.
- `dec_c_out`  in  1  decoder `c_out` result.
- `dec_four_bit`  in  4  decoder `four_bit_out` result.
- `res_bcd`  out  12  captured `BCD` result.
- `res_c_out`  out  1  captured `c_out` result.
- `res_four_bit`  out  4  captured `four_bit_out` result.
- `res_op`  out  4  op code that produced the current `res_*` values.
- `res_valid`  out  1  high once the current run has captured at least one result.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  single-cycle pulse, high only in FINISH.

## Operation
- States: IDLE, SETTLE, CAPTURE, HOLD, FINISH.
- **IDLE, start=1:**
  - Load `dec_a`←`sw_a`, `dec_b`←`sw_b`, `dec_counter_mode`←`sw_counter_mode`.
  - Load the internal mode register ←`auto`.
  - Load `dec_op` ← (`auto` ? 0 : `sw_op`).
  - Clear `res_valid`.
  - Go to SETTLE.
- **IDLE, start=0:** stay; all registers hold.
- **SETTLE:** one cycle with the decoder inputs stable; go to CAPTURE.
- **CAPTURE:**
  - Load `res_bcd`←`dec_bcd`, `res_c_out`←`dec_c_out`, `res_four_bit`←`dec_four_bit`, `res_op`←`dec_op`.
  - Set `res_valid`.
  - Single mode, or sweep with `dec_op`=15 → FINISH.
  - Otherwise load the dwell counter with DWELL−1 → HOLD.
- **HOLD:**
  - Dwell counter ≠ 0: decrement and stay.
  - Dwell counter = 0: `dec_op`←`dec_op`+1 (4-bit), then → SETTLE.
  - `dec_op` never wraps past 15, because CAPTURE exits to FINISH at 15.
- **FINISH:** `done`=1; go to IDLE.
- Operands, counter mode and run mode are frozen for the whole run. Switch changes during a run have no effect.
- `res_*` and `res_valid` hold their values in IDLE until the next accepted start or reset.
- Reset in any state: next state is IDLE and every register/output is 0, including the dwell counter and mode. An in-flight run is abandoned and produces no `done`.
- Reset and start in the same cycle: reset wins.

## Timing
- Reset values: `dec_a`=`dec_b`=`dec_op`=0, `dec_counter_mode`=0, `res_bcd`=0, `res_c_out`=0, `res_four_bit`=0, `res_op`=0, `res_valid`=0, `busy`=0, `done`=0.
- Cycle numbering: cycle 1 is the cycle after the edge that samples `start`.
- Single mode: SETTLE in cycle 1, CAPTURE in cycle 2 (`res_*` valid from cycle 3), FINISH/`done` in cycle 3. IDLE resumes in cycle 4.
- Sweep mode:
  - Ops 0..14 each take 2+DWELL cycles.
  - Op 15 takes 2 cycles (no HOLD).
  - `done` is in cycle 15·(2+DWELL)+3; this is cycle 93 at DWELL=4.
  - Op n is driven on `dec_op` from cycle n·(2+DWELL)+1.
- With `start` held high, runs repeat back-to-back with exactly one IDLE cycle between FINISH and the next SETTLE.
- `busy` is high from cycle 1 through the FINISH cycle inclusive.

## Test plan
- **Reset:** assert `reset` for 2 cycles with random switches → every output 0. Then hold `start`=0 for 10 cycles → outputs unchanged, `busy`=0.
- **Single op:** `sw_a`=3, `sw_b`=5, `sw_op`=2, `auto`=0, one-cycle `start` → `dec_a`=3, `dec_b`=5, `dec_op`=2 in cycle 1; `done` only in cycle 3; `res_op`=2; `res_bcd`/`res_c_out`/`res_four_bit` equal a reference decoder's outputs for (3,5,2,0).
- **Sweep at DWELL=4:** `auto`=1, `sw_a`=9, `sw_b`=7 → `dec_op` steps 0..15 at cycles 1, 7, …, 91; 16 captures each match the reference decoder; `done` in cycle 93; final `res_op`=15.
- **Frozen inputs:** pulse `start` in cycle 20 of a sweep and change `sw_a` to 1 → no restart, `dec_a` stays 9, `done` still in cycle 93.
- **Reset mid-run:** assert `reset` in cycle 40 of a sweep → all outputs 0 next cycle and no `done`. A later start with `auto`=0, `sw_op`=4 completes normally in 3 cycles.
- **Held start:** hold `start`=1 with `auto`=0 → `done` in cycles 3, 7, 11, with `busy` low in cycles 4 and 8.
